// File: rtl/mac_result_accumulator_if.sv
// Beat input and frame-total output of the multiplier result accumulator.
// The accumulator uses the slave view; the producer/consumer pair uses the master view.
interface mac_result_accumulator_if #(
    parameter int ACC_W = 48
);
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic             sign;
    logic [44:0]      result_0;
    logic [44:0]      result_1;
    logic [3:0]       result_SIMD_carry;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_0;
    logic [ACC_W-1:0] acc_1;
    logic             out_mode;
    logic [8:0]       out_beats;
    logic             out_err;

    modport slave (
        input  in_valid, mode, sign, result_0, result_1, result_SIMD_carry, in_last, out_ready,
        output in_ready, out_valid, acc_0, acc_1, out_mode, out_beats, out_err
    );

    modport master (
        output in_valid, mode, sign, result_0, result_1, result_SIMD_carry, in_last, out_ready,
        input  in_ready, out_valid, acc_0, acc_1, out_mode, out_beats, out_err
    );
endinterface

// File: rtl/mac_result_accumulator.sv
// Recombines split 27x18 / SIMD-9x9 multiplier results and accumulates them per frame,
// presenting the frame totals on a valid/ready output.
module mac_result_accumulator #(
    parameter int ACC_W     = 48,
    parameter int MAX_BEATS = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    mac_result_accumulator_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    localparam logic [8:0] LAST_CNT = 9'(MAX_BEATS - 1);

    state_t           state, state_next;
    logic             accept;
    logic             mode_match;
    logic             frame_mode;
    logic [8:0]       beat_cnt;
    logic             err;

    logic [44:0]      prod;
    logic [28:0]      lane0_sum;
    logic [19:0]      lane1_sum;
    logic [ACC_W-1:0] ext0, ext1;

    logic             s1_valid;
    logic [ACC_W-1:0] s1_lane0, s1_lane1;
    logic [ACC_W-1:0] acc0, acc1;

    assign bus.in_ready = (state == IDLE) || (state == ACCUM);
    assign accept       = bus.in_valid && bus.in_ready;
    // The first beat of a frame defines the frame mode, so it always matches.
    assign mode_match   = (state == IDLE) || (bus.mode == frame_mode);

    // Stage-1 combinational recombine of the split partial words.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ext0      = '0;
        ext1      = '0;
        prod      = bus.result_0 + bus.result_1;
        lane0_sum = 29'(bus.result_0[26:0]) + 29'(bus.result_1[26:0])
                  + {bus.result_SIMD_carry[1:0], 27'b0};
        lane1_sum = 20'(bus.result_0[44:27]) + 20'(bus.result_1[44:27])
                  + {bus.result_SIMD_carry[3:2], 18'b0};
        if (bus.mode) begin
            ext0 = bus.sign ? ACC_W'($signed(lane0_sum)) : ACC_W'(lane0_sum);
            ext1 = bus.sign ? ACC_W'($signed(lane1_sum)) : ACC_W'(lane1_sum);
        end else begin
            ext0 = bus.sign ? ACC_W'($signed(prod)) : ACC_W'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_next = (bus.in_last || MAX_BEATS == 1) ? DRAIN : ACCUM;
            end
            ACCUM: begin
                if (accept && (bus.in_last || (mode_match && beat_cnt == LAST_CNT)))
                    state_next = DRAIN;
            end
            DRAIN:   state_next = HOLD;
            HOLD:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s1_lane0   <= '0;
            s1_lane1   <= '0;
            acc0       <= '0;
            acc1       <= '0;
            frame_mode <= 1'b0;
            beat_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            s1_valid <= accept && mode_match;
            s1_lane0 <= ext0;
            s1_lane1 <= ext1;

            if (accept && state == IDLE) begin
                frame_mode <= bus.mode;
                beat_cnt   <= 9'd1;
                err        <= 1'b0;
            end else if (accept) begin
                if (mode_match) beat_cnt <= beat_cnt + 9'd1;
                else            err      <= 1'b1;
            end

            if (s1_valid) begin
                acc0 <= acc0 + s1_lane0;
                acc1 <= acc1 + s1_lane1;
            end

            // Stage 1 is empty in HOLD, so the clear never collides with an add.
            if (state == HOLD && bus.out_ready) begin
                acc0     <= '0;
                acc1     <= '0;
                beat_cnt <= '0;
                err      <= 1'b0;
            end
        end
    end

    assign bus.out_valid = (state == HOLD);
    assign bus.acc_0     = acc0;
    assign bus.acc_1     = acc1;
    assign bus.out_mode  = frame_mode;
    assign bus.out_beats = beat_cnt;
    assign bus.out_err   = err;
endmodule

// File: tb/tb_mac_result_accumulator.sv
// Randomized and directed check of mac_result_accumulator against an arithmetic frame model.
module tb_mac_result_accumulator;
    localparam int ACC_W     = 48;
    localparam int MAX_BEATS = 4;
    localparam longint unsigned ACC_MASK = (64'd1 << ACC_W) - 64'd1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mac_result_accumulator_if #(.ACC_W(ACC_W)) bus ();

    mac_result_accumulator #(.ACC_W(ACC_W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    typedef struct {
        longint unsigned acc0;
        longint unsigned acc1;
        bit              mode;
        int              beats;
        bit              err;
    } frame_t;

    frame_t          exp_q[$];
    bit              m_open = 1'b0;
    bit              m_mode;
    int              m_cnt;
    bit              m_err;
    longint unsigned m_acc0, m_acc1;

    // Two's-complement or zero extension of a width-bit value into the accumulator width.
    function automatic longint unsigned extend(input longint unsigned v, input int width, input bit sgn);
        if (sgn && v[width-1]) return (v - (64'd1 << width)) & ACC_MASK;
        return v;
    endfunction

    function automatic void beat_value(input bit mode, input bit sgn, input longint unsigned r0,
                                       input longint unsigned r1, input longint unsigned c,
                                       output longint unsigned v0, output longint unsigned v1);
        longint unsigned p, l0, l1;
        if (!mode) begin
            p  = (r0 + r1) % (64'd1 << 45);
            v0 = extend(p, 45, sgn);
            v1 = 0;
        end else begin
            l0 = ((r0 % (64'd1 << 27)) + (r1 % (64'd1 << 27)) + (c % 4) * (64'd1 << 27)) % (64'd1 << 29);
            l1 = ((r0 >> 27) + (r1 >> 27) + (c / 4) * (64'd1 << 18)) % (64'd1 << 20);
            v0 = extend(l0, 29, sgn);
            v1 = extend(l1, 20, sgn);
        end
    endfunction

    task automatic model_beat(input bit mode, input bit sgn, input logic [44:0] r0, input logic [44:0] r1,
                              input logic [3:0] c, input bit last, output bit closed);
        longint unsigned v0, v1;
        frame_t f;
        beat_value(mode, sgn, 64'(r0), 64'(r1), 64'(c), v0, v1);
        closed = 1'b0;
        if (!m_open) begin
            m_open = 1'b1; m_mode = mode; m_cnt = 1; m_err = 1'b0;
            m_acc0 = v0;   m_acc1 = v1;
            closed = last || (MAX_BEATS == 1);
        end else if (mode == m_mode) begin
            m_cnt++;
            m_acc0 = (m_acc0 + v0) & ACC_MASK;
            m_acc1 = (m_acc1 + v1) & ACC_MASK;
            closed = last || (m_cnt == MAX_BEATS);
        end else begin
            m_err  = 1'b1;
            closed = last;
        end
        if (closed) begin
            f.acc0 = m_acc0; f.acc1 = m_acc1; f.mode = m_mode; f.beats = m_cnt; f.err = m_err;
            exp_q.push_back(f);
            m_open = 1'b0;
        end
    endtask

    // Presents one beat, holds it until accepted, then feeds the model.
    task automatic send_beat(input bit mode, input bit sgn, input logic [44:0] r0, input logic [44:0] r1,
                             input logic [3:0] c, input bit last, output bit closed);
        int waited = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.mode = mode; bus.sign = sgn;
        bus.result_0 = r0; bus.result_1 = r1; bus.result_SIMD_carry = c; bus.in_last = last;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("in_ready_wait", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            closed = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        model_beat(mode, sgn, r0, r1, c, last, closed);
    endtask

    // Called right after the closing beat is accepted; out_valid must be seen on the second falling edge.
    task automatic await_frame(output frame_t e);
        int n = 0;
        e = '{default: 0};
        if (exp_q.size() == 0) begin
            check("frame_expected", 64'(bus.out_valid), 64'd0);
            return;
        end
        e = exp_q.pop_front();
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        check("out_valid_latency", 64'(n), 64'd2);
        check("acc_0", 64'(bus.acc_0), e.acc0);
        check("acc_1", 64'(bus.acc_1), e.acc1);
        check("out_mode", 64'(bus.out_mode), 64'(e.mode));
        check("out_beats", 64'(bus.out_beats), 64'(e.beats));
        check("out_err", 64'(bus.out_err), 64'(e.err));
        check("in_ready_hold", 64'(bus.in_ready), 64'd0);
    endtask

    task automatic release_frame(input frame_t e, input int hold_cycles);
        for (int k = 0; k < hold_cycles; k++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_acc_0", 64'(bus.acc_0), e.acc0);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("post_valid", 64'(bus.out_valid), 64'd0);
        check("post_acc_0", 64'(bus.acc_0), 64'd0);
        check("post_acc_1", 64'(bus.acc_1), 64'd0);
        check("post_beats", 64'(bus.out_beats), 64'd0);
        check("post_err", 64'(bus.out_err), 64'd0);
        check("post_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_acc_0"}, 64'(bus.acc_0), 64'd0);
        check({tag, "_acc_1"}, 64'(bus.acc_1), 64'd0);
        check({tag, "_beats"}, 64'(bus.out_beats), 64'd0);
        check({tag, "_err"}, 64'(bus.out_err), 64'd0);
        check({tag, "_mode"}, 64'(bus.out_mode), 64'd0);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        frame_t      e;
        bit          closed;
        bit          fm, bm, sg, last;
        int          i;
        logic [63:0] w0, w1;

        bus.in_valid = 1'b0; bus.mode = 1'b0; bus.sign = 1'b0;
        bus.result_0 = '0; bus.result_1 = '0; bus.result_SIMD_carry = '0;
        bus.in_last = 1'b0; bus.out_ready = 1'b0;

        // Reset held for two edges.
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        reset = 1'b1;

        // Signed 27x18 single beat: -16 + 5 = -11.
        send_beat(1'b0, 1'b1, 45'h1FFF_FFFF_FFF0, 45'h5, 4'h0, 1'b1, closed);
        await_frame(e);
        check("t2_acc_0_const", 64'(bus.acc_0), 64'hFFFF_FFFF_FFF5);
        check("t2_beats_const", 64'(bus.out_beats), 64'd1);
        release_frame(e, 1);

        // Unsigned SIMD frame of three identical beats.
        for (int k = 0; k < 3; k++)
            send_beat(1'b1, 1'b0, {18'd7, 27'd100}, {18'd0, 27'd20}, 4'h0, k == 2, closed);
        await_frame(e);
        check("t3_acc_0_const", 64'(bus.acc_0), 64'd360);
        check("t3_acc_1_const", 64'(bus.acc_1), 64'd21);
        check("t3_mode_const", 64'(bus.out_mode), 64'd1);
        release_frame(e, 0);

        // 27x18 frame with a SIMD beat dropped in the middle.
        send_beat(1'b0, 1'b0, 45'd100, 45'd23, 4'h0, 1'b0, closed);
        send_beat(1'b1, 1'b0, 45'h1234_5678, 45'h9ABC, 4'hF, 1'b0, closed);
        send_beat(1'b0, 1'b0, 45'd1000, 45'd0, 4'h0, 1'b1, closed);
        await_frame(e);
        check("t4_acc_0_const", 64'(bus.acc_0), 64'd1123);
        check("t4_err_const", 64'(bus.out_err), 64'd1);
        check("t4_beats_const", 64'(bus.out_beats), 64'd2);
        release_frame(e, 2);

        // Beat limit closes the frame; the next beat waits through the output handshake.
        for (int k = 0; k < 4; k++)
            send_beat(1'b0, 1'b0, 45'(k + 1), 45'd0, 4'h0, 1'b0, closed);
        check("t5_closed_by_limit", 64'(bus.in_ready), 64'd0);
        await_frame(e);
        check("t5_acc_0_const", 64'(bus.acc_0), 64'd10);
        fork
            release_frame(e, 2);
            send_beat(1'b0, 1'b0, 45'd50, 45'd0, 4'h0, 1'b0, closed);
        join
        send_beat(1'b0, 1'b0, 45'd60, 45'd0, 4'h0, 1'b1, closed);
        await_frame(e);
        check("t5b_acc_0_const", 64'(bus.acc_0), 64'd110);
        release_frame(e, 0);

        // Reset while holding totals discards them.
        send_beat(1'b1, 1'b1, 45'h1F_FFFF_FFFF, 45'h3, 4'h5, 1'b0, closed);
        send_beat(1'b1, 1'b1, 45'h7_0000_0001, 45'h2, 4'hA, 1'b1, closed);
        await_frame(e);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t6_hold_acc_0", 64'(bus.acc_0), e.acc0);
            check("t6_hold_acc_1", 64'(bus.acc_1), e.acc1);
            check("t6_hold_valid", 64'(bus.out_valid), 64'd1);
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_cleared("t6_reset");
        reset = 1'b1;

        // Reset mid-frame discards the partial frame.
        send_beat(1'b0, 1'b1, 45'd77, 45'd1, 4'h0, 1'b0, closed);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_cleared("midframe_reset");
        reset = 1'b1;
        m_open = 1'b0;

        // Randomized frames with occasional mode-mismatch beats.
        for (int f = 0; f < 30; f++) begin
            fm = 1'($urandom_range(0, 1));
            closed = 1'b0;
            i = 0;
            while (!closed && i < 20) begin
                bm   = (m_open && $urandom_range(0, 6) == 0) ? ~fm : fm;
                sg   = 1'($urandom_range(0, 1));
                last = ($urandom_range(0, 2) == 0) || (i >= 8);
                w0   = {$urandom(), $urandom()};
                w1   = {$urandom(), $urandom()};
                send_beat(bm, sg, w0[44:0], w1[44:0], 4'($urandom_range(0, 15)), last, closed);
                i++;
            end
            await_frame(e);
            release_frame(e, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mac_result_accumulator.md
Name: mac_result_accumulator

Overview:
- Consumer end of the 27x18 / SIMD-9x9 multiplier result interface.
- Each beat takes the split pair result_0/result_1 plus result_SIMD_carry and recombines it into a signed product (27x18 mode) or two lane sums (SIMD mode).
- Accumulates these over a frame delimited by in_last, then presents the totals on a valid/ready output.
- Sits between the partial-product array and the DSP post-adder/writeback.

Parameters:
ACC_W, 48, accumulator width per lane (≥ 45)
MAX_BEATS, 256, beat limit per frame; reaching it closes the frame as if in_last

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
mode  in  1  0 = 27x18, 1 = sum-of-9x9 SIMD
sign  in  1  a_sign|b_sign of the producing multiply; 1 = operands signed
result_0  in  45  first partial result word
result_1  in  45  second partial result word
result_SIMD_carry  in  4  lane carries: [1:0] lane0, [3:2] lane1
in_last  in  1  final beat of frame
out_valid  out  1  frame totals valid
out_ready  in  1  downstream accepts totals
acc_0  out  ACC_W  27x18 total, or SIMD lane0 total
acc_1  out  ACC_W  SIMD lane1 total; 0 in 27x18 mode
out_mode  out  1  mode latched for the frame
out_beats  out  9  beats accumulated, 1..MAX_BEATS
out_err  out  1  ≥1 beat dropped for mode mismatch

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE. All outputs 0 except in_ready=1. Accumulators and counters cleared.
- Reset overrides everything, including mid-frame and HOLD; the partial frame is discarded.
- Handshake: a beat is accepted on in_valid & in_ready. Outputs are consumed on out_valid & out_ready.
- in_ready = 1 in IDLE and ACCUM, 0 in DRAIN and HOLD.
- Recombine (stage 1, registered):
  - Mode 0: P = result_0 + result_1 mod 2^45. Sign-extended to ACC_W if sign, else zero-extended. Lane1 contribution = 0.
  - Mode 1, lane0: L0 = (result_0[26:0] + result_1[26:0] + {result_SIMD_carry[1:0], 27'b0}) mod 2^29.
  - Mode 1, lane1: L1 = (result_0[44:27] + result_1[44:27] + {result_SIMD_carry[3:2], 18'b0}) mod 2^20.
  - L0 and L1 are each sign- or zero-extended by sign.
- Accumulate (stage 2): acc += extended value, wrapping mod 2^ACC_W. No saturation.
- FSM:
  - IDLE: an accepted beat latches frame mode and starts the frame. Goes to DRAIN if in_last or MAX_BEATS==1, else to ACCUM.
  - ACCUM: each accepted beat increments the beat count. Goes to DRAIN on in_last or when count reaches MAX_BEATS.
  - DRAIN: one cycle while the final beat passes stage 2, then to HOLD.
  - HOLD: out_valid=1. Outputs stay stable until out_ready. On handshake, accumulators, count and err are cleared and the FSM returns to IDLE. in_ready rises the following cycle.
- Latency: out_valid rises 2 cycles after the edge that accepted the closing beat.
- Mode mismatch:
  - A beat whose mode differs from the latched frame mode is accepted but not accumulated, and not counted.
  - It sets out_err (sticky for the frame).
  - If that beat carries in_last, the frame still closes.
  - If every beat of a frame is dropped, out_beats = 0 is reported.
- Signedness of the latched frame is per-beat, not latched.
- in_valid while in_ready=0 is ignored; the producer must hold the beat.
- Simultaneous out_ready and in_valid in HOLD: the output handshake completes; the input beat is not accepted that cycle.

Test Plan:
1. Reset with reset=0 for 2 cycles -> out_valid=0, acc_0=acc_1=0, in_ready=1.
2. Mode 0, sign=1, single beat with result_0=45'h1FFF_FFFF_FFF0, result_1=45'h5, in_last=1 -> 2 cycles later out_valid=1, acc_0 = −11 sign-extended (48'hFFFF_FFFF_FFF5), acc_1=0, out_beats=1.
3. Mode 1, sign=0, 3 beats each with result_0[26:0]=100, result_1[26:0]=20, result_0[44:27]=7, result_1[44:27]=0, carry=0 -> acc_0=360, acc_1=21, out_mode=1, out_beats=3.
4. Mode 0 frame of 2 beats with a mode-1 beat between them -> out_err=1, out_beats=2, acc_0 = sum of the two mode-0 beats only.
5. MAX_BEATS=4, in_last held 0 for 6 beats -> frame closes after beat 4, out_beats=4, in_ready=0 until out_ready handshake; beats 5–6 start the next frame.
6. out_ready held 0 for 10 cycles in HOLD, then assert reset=0 mid-HOLD -> outputs stable through the hold, then all cleared on the reset edge, in_ready=1.
